// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the SRAM data-memory controller.
package mem_ctrl_pkg;

    // Access sequencer states: two halfword phases bracketed by idle/done.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int DEF_BASE_ADDR   = 1024;
    localparam int DEF_WAIT_CYCLES = 2;

    // Counter width able to hold WAIT_CYCLES-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Load/decrement wait counter with a zero flag; times each SRAM halfword phase.
module sram_wait_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q, count_d;

    // Load has priority over decrement.
    always_comb begin
        count_d = count_q;
        if (load_i)
            count_d = load_val_i;
        else if (dec_i)
            count_d = count_q - WIDTH'(1);
    end

    // Counter register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/sram_mem_controller.sv
// Splits MEM-stage 32-bit loads/stores into two timed halfword accesses
// on a 16-bit asynchronous SRAM; ready low freezes the pipeline.
module sram_mem_controller
    import mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int BASE_ADDR   = DEF_BASE_ADDR,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    localparam int             CW       = cnt_width(WAIT_CYCLES);
    localparam logic [CW-1:0]  LOAD_VAL = CW'(WAIT_CYCLES - 1);
    localparam int             WW       = SRAM_AW - 1;

    state_e             state_q;
    logic               is_wr_q;
    logic [WW-1:0]      word_q;
    logic [31:0]        wdata_q;
    logic [31:0]        read_data_q;
    logic [SRAM_AW-1:0] sram_addr_q;
    logic [15:0]        dq_out_q;
    logic               dq_oe_q;
    logic               we_n_q;
    logic               oe_n_q;

    logic               req;
    logic [WW-1:0]      word_in;
    logic               cnt_load;
    logic               cnt_dec;
    logic               cnt_zero;

    assign req     = rd_en | wr_en;
    // Out-of-range addresses simply wrap into the SRAM; no error path.
    assign word_in = WW'((address - 32'(BASE_ADDR)) >> 2);

    // Reload on entry to each halfword phase, then count down to zero.
    assign cnt_load = ((state_q == IDLE) && req) || ((state_q == LOW) && cnt_zero);
    assign cnt_dec  = ((state_q == LOW) || (state_q == HIGH)) && !cnt_zero;

    sram_wait_counter #(.WIDTH(CW)) u_wait (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (LOAD_VAL),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Access sequencer; SRAM pins are registered so they are glitch-free
    // and change only on phase boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            is_wr_q     <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (req) begin
                    // Store wins when both enables are set.
                    is_wr_q     <= wr_en;
                    word_q      <= word_in;
                    wdata_q     <= write_data;
                    sram_addr_q <= {word_in, 1'b0};
                    if (wr_en) begin
                        we_n_q   <= 1'b0;
                        dq_oe_q  <= 1'b1;
                        dq_out_q <= write_data[15:0];
                    end else begin
                        oe_n_q   <= 1'b0;
                    end
                    state_q <= LOW;
                end
                LOW: if (cnt_zero) begin
                    if (!is_wr_q)
                        read_data_q[15:0] <= sram_dq_in;
                    else
                        dq_out_q <= wdata_q[31:16];
                    sram_addr_q <= {word_q, 1'b1};
                    state_q     <= HIGH;
                end
                HIGH: if (cnt_zero) begin
                    if (!is_wr_q)
                        read_data_q[31:16] <= sram_dq_in;
                    we_n_q   <= 1'b1;
                    oe_n_q   <= 1'b1;
                    dq_oe_q  <= 1'b0;
                    dq_out_q <= '0;
                    state_q  <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Idle with no request, or the single completion cycle.
    assign ready = ((state_q == IDLE) && !req) || (state_q == DONE);

    assign read_data   = read_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;
    assign sram_oe_n   = oe_n_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Scoreboard bench: driver issues loads/stores and pushes expectations from a
// word-level memory model; a negedge monitor checks bus phases and completions.
module tb_sram_mem_controller;

    localparam int W    = 2;
    localparam int BASE = 1024;
    localparam int AW   = 18;
    localparam int NW   = 1 << (AW - 1);

    logic          clk = 1'b0;
    logic          rst, rd_en, wr_en;
    logic [31:0]   address, write_data, read_data;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out, sram_dq_in;
    logic          sram_dq_oe, sram_we_n, sram_oe_n;

    always #5 clk = ~clk;

    sram_mem_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE), .SRAM_AW(AW)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    // Halfword SRAM device and word-level reference memory.
    logic [15:0] sram    [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:NW-1];
    logic [31:0] last_read;

    assign sram_dq_in = !sram_oe_n ? sram[sram_addr] : 16'h0;

    initial forever begin
        @(negedge clk);
        if (rst === 1'b0 && sram_we_n === 1'b0) sram[sram_addr] = sram_dq_out;
    end

    typedef struct {
        bit          wr;
        int          word;
        logic [31:0] data;
        logic [31:0] exp_rd;
    } txn_t;
    txn_t q[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'(BASE);
        return int'((off / 4) % NW);
    endfunction

    // Monitor: per-cycle bus phase checks and completion checks.
    initial begin
        int   busy, wcnt, k;
        txn_t t;
        logic [AW-1:0] hw;
        busy = 0; wcnt = 0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                if (busy > 0 && q.size() > 0) void'(q.pop_front());
                busy = 0; wcnt = 0;
            end else if (ready === 1'b0) begin
                chk("outstanding", 64'(q.size()), 64'd1);
                if (q.size() > 0) begin
                    t = q[0];
                    k = busy;
                    if (k >= 1 && k <= 2*W) begin
                        hw = AW'(t.word * 2 + ((k > W) ? 1 : 0));
                        if (t.wr)
                            chk("wr_phase", {sram_addr, sram_we_n, sram_oe_n, sram_dq_oe, sram_dq_out},
                                {hw, 1'b0, 1'b1, 1'b1, (k > W) ? t.data[31:16] : t.data[15:0]});
                        else
                            chk("rd_phase", {sram_addr, sram_we_n, sram_oe_n, sram_dq_oe},
                                {hw, 1'b1, 1'b0, 1'b0});
                    end
                end
                if (sram_we_n === 1'b0) wcnt++;
                busy++;
            end else begin
                chk("idle_ctrl", {sram_we_n, sram_oe_n, sram_dq_oe}, 3'b110);
                if (busy > 0) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        $display("FAIL completion: got completion expected none pending");
                    end else begin
                        t = q.pop_front();
                        chk("latency", 64'(busy), 64'(2*W+1));
                        chk("read_data", read_data, t.exp_rd);
                        chk("we_cycles", 64'(wcnt), t.wr ? 64'(2*W) : 64'd0);
                        if (t.wr)
                            chk("sram_word", {sram[2*t.word+1], sram[2*t.word]}, t.data);
                    end
                    busy = 0; wcnt = 0;
                end
            end
        end
    end

    // Issue one access, hold it until ready, scrambling address/data mid-access.
    task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        int   n;
        bit   done;
        t.wr = wr; t.word = word_of(a); t.data = d;
        if (wr) begin
            ref_mem[t.word] = d;
            t.exp_rd = last_read;
        end else begin
            t.exp_rd = ref_mem[t.word];
            last_read = t.exp_rd;
        end
        q.push_back(t);
        rd_en = rd; wr_en = wr; address = a; write_data = d;
        n = 0; done = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (ready === 1'b1) done = 1;
            else if (n >= 2) begin
                #1 address = $urandom; write_data = $urandom;
            end
        end
        if (!done) begin
            n_chk++;
            $display("FAIL ready_timeout: got no ready after %0d cycles expected %0d", n, 2*W+1);
        end
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 9) == 0)
            return 32'(BASE - 4) + 32'($urandom_range(0, 3));
        return 32'(BASE) + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [31:0] v;
        txn_t        t;
        for (int i = 0; i < (1 << AW); i++) sram[i] = 16'h0;
        for (int i = 0; i < NW; i++) ref_mem[i] = 32'h0;
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            ref_mem[i] = v; sram[2*i] = v[15:0]; sram[2*i+1] = v[31:16];
        end
        last_read = 32'h0;

        // Reset with no requests.
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", ready, 1'b1);
        chk("reset_ctrl", {sram_we_n, sram_oe_n, sram_dq_oe}, 3'b110);
        chk("reset_bus", {sram_addr, sram_dq_out}, '0);
        chk("reset_rdata", read_data, 32'h0);
        @(posedge clk); #1;

        // Directed load, store, and simultaneous enables.
        sram[2] = 16'h5678; sram[3] = 16'h1234; ref_mem[1] = 32'h12345678;
        issue(1'b1, 1'b0, 32'd1028, 32'h0);
        issue(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
        issue(1'b1, 1'b1, 32'd1032, 32'hA5A5C3C3);

        // Reset during the second HIGH cycle of a store.
        t.wr = 1'b1; t.word = 10; t.data = 32'h0BAD_F00D; t.exp_rd = 32'h0;
        q.push_back(t);
        wr_en = 1'b1; address = 32'(BASE + 40); write_data = t.data;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        last_read = 32'h0;
        @(negedge clk);
        chk("midrst_ctrl", {sram_we_n, sram_oe_n, sram_dq_oe}, 3'b110);
        chk("midrst_ready", ready, 1'b1);
        chk("midrst_rdata", read_data, 32'h0);
        chk("midrst_addr", sram_addr, '0);
        sram[20] = ref_mem[10][15:0]; sram[21] = ref_mem[10][31:16];
        @(posedge clk); #1;

        // Back-to-back loads.
        issue(1'b1, 1'b0, 32'd1024, 32'h0);
        issue(1'b1, 1'b0, 32'd1028, 32'h0);

        // Randomized traffic with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            bit r, w;
            r = 1'($urandom_range(0, 1));
            w = r ? 1'($urandom_range(0, 3) == 0) : 1'b1;
            issue(r, w, rand_addr(), $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
